risc_multicycle: RTL and testbench



---
 rtl/risc_multicycle.sv | 228 ++++++++++++++++++++++
 tb/tb_risc_multicycle.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_multicycle.sv
// Multi-cycle 16-bit RISC core: instruction RAM, register file and data RAM,
// sequenced FETCH/DECODE/EXEC/MEM/WB with branch, jump, halt and a retired-instruction counter.
module risc_multicycle #(
    parameter int REG_ADDR_WIDTH  = 4,
    parameter int REG_DATA_WIDTH  = 16,
    parameter int IMEM_ADDR_WIDTH = 6,
    parameter int DMEM_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                       Clk_i,
    input  logic                       Rst_i,
    input  logic                       Inst_wen_i,
    input  logic [IMEM_ADDR_WIDTH-1:0] Inst_waddr_i,
    input  logic [15:0]                Input_inst_i,
    input  logic                       Start_i,
    input  logic [REG_ADDR_WIDTH-1:0]  Dbg_raddr_i,
    output logic [REG_DATA_WIDTH-1:0]  Dbg_rdata_o,
    output logic [IMEM_ADDR_WIDTH-1:0] Pc_o,
    output logic                       Busy_o,
    output logic                       Halt_o,
    output logic [CNT_WIDTH-1:0]       Retired_o
);
    localparam int REG_COUNT  = 2 ** REG_ADDR_WIDTH;
    localparam int IMEM_DEPTH = 2 ** IMEM_ADDR_WIDTH;
    localparam int DMEM_DEPTH = 2 ** DMEM_ADDR_WIDTH;
    localparam int PC_WIDE    = IMEM_ADDR_WIDTH + 9;
    localparam int DATA_WIDE  = REG_DATA_WIDTH + 9;
    localparam int ADDR_WIDE  = REG_DATA_WIDTH + DMEM_ADDR_WIDTH + 5;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_LDI   = 3'b010;
    localparam logic [2:0] OP_ALU   = 3'b011;
    localparam logic [2:0] OP_MAC   = 3'b100;
    localparam logic [2:0] OP_BEQZ  = 3'b101;
    localparam logic [2:0] OP_JMP   = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED
    } state_t;

    state_t                       state_q, state_d;
    logic [IMEM_ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [CNT_WIDTH-1:0]         retired_q, retired_d;
    logic [15:0]                  ir_q, ir_d;
    logic [REG_DATA_WIDTH-1:0]    op_a_q, op_a_d, op_b_q, op_b_d, op_c_q, op_c_d;
    logic [REG_DATA_WIDTH-1:0]    result_q, result_d;
    logic [DMEM_ADDR_WIDTH-1:0]   maddr_q, maddr_d;

    logic [15:0]                  imem_q [IMEM_DEPTH];
    logic [REG_DATA_WIDTH-1:0]    dmem_q [DMEM_DEPTH];
    logic [REG_DATA_WIDTH-1:0]    rf_q   [REG_COUNT];
    logic [15:0]                  imem_rdata_q;
    logic [REG_DATA_WIDTH-1:0]    dmem_rdata_q;

    logic                         imem_we, dmem_we, rf_we;
    logic [REG_DATA_WIDTH-1:0]    rf_wdata;

    logic [2:0]                   opcode;
    logic                         funct;
    logic [REG_ADDR_WIDTH-1:0]    rd_idx, dec_rd, dec_rs1, dec_rs2;
    logic [PC_WIDE-1:0]           br_off_wide, jmp_wide;
    logic [DATA_WIDE-1:0]         imm9_wide;
    logic [ADDR_WIDE-1:0]         addr_wide;
    logic [REG_DATA_WIDTH-1:0]    product;
    logic [IMEM_ADDR_WIDTH-1:0]   pc_inc, br_target;
    logic                         unused_bits;

    assign opcode  = ir_q[15:13];
    assign funct   = ir_q[0];
    assign rd_idx  = ir_q[9 +: REG_ADDR_WIDTH];
    // Operands are fetched straight from the RAM output while IR is being loaded.
    assign dec_rd  = imem_rdata_q[9 +: REG_ADDR_WIDTH];
    assign dec_rs1 = imem_rdata_q[5 +: REG_ADDR_WIDTH];
    assign dec_rs2 = imem_rdata_q[1 +: REG_ADDR_WIDTH];

    assign br_off_wide = PC_WIDE'($signed(ir_q[8:0]));
    assign jmp_wide    = PC_WIDE'(ir_q[8:0]);
    assign imm9_wide   = DATA_WIDE'(ir_q[8:0]);
    assign addr_wide   = ADDR_WIDE'(op_a_q) + ADDR_WIDE'(ir_q[4:0]);
    assign product     = op_a_q * op_b_q;
    assign pc_inc      = pc_q + IMEM_ADDR_WIDTH'(1);
    assign br_target   = pc_q + br_off_wide[IMEM_ADDR_WIDTH-1:0];
    assign rf_wdata    = (opcode == OP_LOAD) ? dmem_rdata_q : result_q;

    assign unused_bits = ^{br_off_wide[PC_WIDE-1:IMEM_ADDR_WIDTH], jmp_wide[PC_WIDE-1:IMEM_ADDR_WIDTH],
                           imm9_wide[DATA_WIDE-1:REG_DATA_WIDTH], addr_wide[ADDR_WIDE-1:DMEM_ADDR_WIDTH]};

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        ir_d      = ir_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        op_c_d    = op_c_q;
        result_d  = result_q;
        maddr_d   = maddr_q;
        imem_we   = 1'b0;
        dmem_we   = 1'b0;
        rf_we     = 1'b0;
        case (state_q)
            S_IDLE, S_HALTED: begin
                imem_we = Inst_wen_i && !Rst_i;
                if (Start_i) begin
                    state_d   = S_FETCH;
                    pc_d      = '0;
                    retired_d = '0;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                ir_d    = imem_rdata_q;
                op_a_d  = rf_q[dec_rs1];
                op_b_d  = rf_q[dec_rs2];
                op_c_d  = rf_q[dec_rd];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (opcode)
                    OP_LOAD, OP_STORE: begin
                        maddr_d = addr_wide[DMEM_ADDR_WIDTH-1:0];
                        state_d = S_MEM;
                    end
                    OP_LDI: begin
                        result_d = imm9_wide[REG_DATA_WIDTH-1:0];
                        state_d  = S_WB;
                    end
                    OP_ALU: begin
                        result_d = funct ? (op_a_q - op_b_q) : (op_a_q + op_b_q);
                        state_d  = S_WB;
                    end
                    OP_MAC: begin
                        result_d = funct ? product : (op_c_q + product);
                        state_d  = S_WB;
                    end
                    OP_BEQZ: begin
                        pc_d      = (op_c_q == '0) ? br_target : pc_inc;
                        retired_d = retired_q + CNT_WIDTH'(1);
                        state_d   = S_FETCH;
                    end
                    OP_JMP: begin
                        pc_d      = jmp_wide[IMEM_ADDR_WIDTH-1:0];
                        retired_d = retired_q + CNT_WIDTH'(1);
                        state_d   = S_FETCH;
                    end
                    default: begin
                        // HALT retires but leaves PC pointing at itself.
                        retired_d = retired_q + CNT_WIDTH'(1);
                        state_d   = S_HALTED;
                    end
                endcase
            end
            S_MEM: begin
                if (opcode == OP_LOAD) begin
                    state_d = S_WB;
                end else begin
                    dmem_we   = 1'b1;
                    pc_d      = pc_inc;
                    retired_d = retired_q + CNT_WIDTH'(1);
                    state_d   = S_FETCH;
                end
            end
            S_WB: begin
                rf_we     = 1'b1;
                pc_d      = pc_inc;
                retired_d = retired_q + CNT_WIDTH'(1);
                state_d   = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            retired_q <= '0;
            ir_q      <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_c_q    <= '0;
            result_q  <= '0;
            maddr_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            ir_q      <= ir_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            op_c_q    <= op_c_d;
            result_q  <= result_d;
            maddr_q   <= maddr_d;
        end
    end

    // r0 is never written, so it reads as zero everywhere.
    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we && (rd_idx != '0)) begin
            rf_q[rd_idx] <= rf_wdata;
        end
    end

    always_ff @(posedge Clk_i) begin
        if (imem_we) begin
            imem_q[Inst_waddr_i] <= Input_inst_i;
        end
        imem_rdata_q <= imem_q[pc_q];
    end

    always_ff @(posedge Clk_i) begin
        if (dmem_we && !Rst_i) begin
            dmem_q[maddr_q] <= op_c_q;
        end
        dmem_rdata_q <= dmem_q[maddr_q];
    end

    assign Dbg_rdata_o = rf_q[Dbg_raddr_i];
    assign Pc_o        = pc_q;
    assign Retired_o   = retired_q;
    assign Busy_o      = (state_q != S_IDLE) && (state_q != S_HALTED);
    assign Halt_o      = (state_q == S_HALTED);
endmodule

// File: tb/tb_risc_multicycle.sv
// Bench for risc_multicycle: directed programs plus random programs, each compared
// against an instruction-level model of the architecture kept in this file.
module tb_risc_multicycle;
    logic        Clk_i = 1'b0;
    logic        Rst_i = 1'b1;
    logic        Inst_wen_i = 1'b0;
    logic [5:0]  Inst_waddr_i = '0;
    logic [15:0] Input_inst_i = '0;
    logic        Start_i = 1'b0;
    logic [3:0]  Dbg_raddr_i = '0;
    logic [15:0] Dbg_rdata_o;
    logic [5:0]  Pc_o;
    logic        Busy_o;
    logic        Halt_o;
    logic [15:0] Retired_o;

    risc_multicycle dut (
        .Clk_i(Clk_i), .Rst_i(Rst_i), .Inst_wen_i(Inst_wen_i), .Inst_waddr_i(Inst_waddr_i),
        .Input_inst_i(Input_inst_i), .Start_i(Start_i), .Dbg_raddr_i(Dbg_raddr_i),
        .Dbg_rdata_o(Dbg_rdata_o), .Pc_o(Pc_o), .Busy_o(Busy_o), .Halt_o(Halt_o),
        .Retired_o(Retired_o)
    );

    always #5 Clk_i = ~Clk_i;

    localparam logic [15:0] HALT = 16'hE000;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] prog   [64];
    logic [15:0] m_imem [64];
    logic [15:0] m_rf   [16];
    logic [15:0] m_dmem [32];
    int          m_pc, m_ret;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc_r(input int op, input int rd, input int rs1, input int rs2, input int f);
        return {op[2:0], rd[3:0], rs1[3:0], rs2[3:0], f[0]};
    endfunction
    function automatic logic [15:0] enc_i5(input int op, input int rd, input int rs1, input int imm5);
        return {op[2:0], rd[3:0], rs1[3:0], imm5[4:0]};
    endfunction
    function automatic logic [15:0] enc_i9(input int op, input int rd, input int imm9);
        return {op[2:0], rd[3:0], imm9[8:0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_rf[i] = '0;
    endtask

    task automatic model_wr(input int r, input logic [15:0] v);
        if (r != 0) m_rf[r] = v;
    endtask

    // Architectural interpreter: one loop iteration per instruction, cycles from the CPI table.
    task automatic model_run(output int cyc);
        bit done;
        logic [15:0] w, a, b, c;
        int op, rd, rs1, rs2, f, imm5, imm9, nxt, s;
        m_pc = 0; m_ret = 0; cyc = 0; done = 0;
        for (int n = 0; n < 4000 && !done; n++) begin
            w = m_imem[m_pc];
            op = int'(w[15:13]); rd = int'(w[12:9]); rs1 = int'(w[8:5]); rs2 = int'(w[4:1]);
            f = int'(w[0]); imm5 = int'(w[4:0]); imm9 = int'(w[8:0]);
            a = m_rf[rs1]; b = m_rf[rs2]; c = m_rf[rd];
            nxt = (m_pc + 1) % 64;
            case (op)
                0: begin model_wr(rd, m_dmem[(int'(a) + imm5) % 32]); cyc += 5; end
                1: begin m_dmem[(int'(a) + imm5) % 32] = c; cyc += 4; end
                2: begin model_wr(rd, 16'(imm9)); cyc += 4; end
                3: begin model_wr(rd, (f != 0) ? 16'(a - b) : 16'(a + b)); cyc += 4; end
                4: begin model_wr(rd, (f != 0) ? 16'(a * b) : 16'(c + a * b)); cyc += 4; end
                5: begin
                    if (c == 16'd0) begin
                        s = (imm9 >= 256) ? imm9 - 512 : imm9;
                        nxt = ((m_pc + s) % 64 + 64) % 64;
                    end
                    cyc += 3;
                end
                6: begin nxt = imm9 % 64; cyc += 3; end
                default: begin done = 1; nxt = m_pc; cyc += 3; end
            endcase
            m_ret++;
            m_pc = nxt;
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) prog[i] = HALT;
    endtask

    task automatic load_prog();
        @(negedge Clk_i);
        for (int i = 0; i < 64; i++) begin
            Inst_wen_i = 1'b1; Inst_waddr_i = 6'(i); Input_inst_i = prog[i];
            m_imem[i] = prog[i];
            @(negedge Clk_i);
        end
        Inst_wen_i = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge Clk_i);
        Start_i = 1'b1;
        @(negedge Clk_i);
        Start_i = 1'b0;
    endtask

    task automatic wait_halt(input int base, output int cyc);
        bit ok;
        cyc = base; ok = 0;
        for (int i = 0; i < 3000; i++) begin
            if (Halt_o) begin ok = 1; break; end
            if (Busy_o) cyc++;
            @(negedge Clk_i);
        end
        check_val("halt_reached", 32'(ok), 32'd1);
    endtask

    task automatic read_reg(input int r, output logic [15:0] v);
        Dbg_raddr_i = 4'(r);
        #1;
        v = Dbg_rdata_o;
    endtask

    task automatic compare_run(input string tag, input int cyc, input int mcyc);
        logic [15:0] v;
        check_val({tag, "_cycles"}, 32'(cyc), 32'(mcyc));
        check_val({tag, "_pc"}, 32'(Pc_o), 32'(m_pc));
        check_val({tag, "_retired"}, 32'(Retired_o), 32'(m_ret));
        for (int r = 0; r < 16; r++) begin
            read_reg(r, v);
            check_val($sformatf("%s_r%0d", tag, r), 32'(v), 32'(m_rf[r]));
        end
        $display("run %s: cycles=%0d pc=%0d retired=%0d", tag, cyc, Pc_o, Retired_o);
    endtask

    task automatic run_prog(input string tag, output int cyc);
        int mcyc;
        pulse_start();
        wait_halt(0, cyc);
        model_run(mcyc);
        compare_run(tag, cyc, mcyc);
    endtask

    initial begin
        int cyc, mcyc, len, kind;
        logic [15:0] v;

        model_reset();
        for (int i = 0; i < 32; i++) m_dmem[i] = '0;
        repeat (2) @(negedge Clk_i);
        check_val("rst_busy", 32'(Busy_o), 32'd0);
        check_val("rst_halt", 32'(Halt_o), 32'd0);
        check_val("rst_pc", 32'(Pc_o), 32'd0);
        check_val("rst_retired", 32'(Retired_o), 32'd0);
        read_reg(5, v);
        check_val("rst_r5", 32'(v), 32'd0);
        Rst_i = 1'b0;

        // Zero the data RAM so later loads are well defined.
        clear_prog();
        for (int i = 0; i < 32; i++) prog[i] = enc_i5(1, 0, 0, i);
        load_prog();
        run_prog("dmem_init", cyc);

        clear_prog();
        prog[0] = enc_i9(2, 1, 5); prog[1] = enc_i9(2, 2, 7); prog[2] = enc_r(3, 3, 1, 2, 0);
        load_prog();
        run_prog("add", cyc);
        read_reg(3, v);
        check_val("add_r3", 32'(v), 32'd12);
        check_val("add_cycles15", 32'(cyc), 32'd15);
        check_val("add_pc3", 32'(Pc_o), 32'd3);
        check_val("add_ret4", 32'(Retired_o), 32'd4);

        clear_prog();
        prog[0] = enc_i9(2, 1, 3); prog[1] = enc_i9(2, 2, 4); prog[2] = enc_i9(2, 4, 10);
        prog[3] = enc_r(4, 4, 1, 2, 0); prog[4] = enc_r(4, 5, 2, 2, 1); prog[5] = enc_r(3, 6, 1, 2, 1);
        load_prog();
        run_prog("mac", cyc);
        read_reg(4, v); check_val("mac_r4", 32'(v), 32'd22);
        read_reg(5, v); check_val("mac_r5", 32'(v), 32'd16);
        read_reg(6, v); check_val("sub_r6", 32'(v), 32'hFFFF);

        clear_prog();
        prog[0] = enc_i9(2, 1, 9'h1AB); prog[1] = enc_i9(2, 2, 30);
        prog[2] = enc_i5(1, 1, 2, 5); prog[3] = enc_i5(0, 7, 2, 5);
        load_prog();
        run_prog("ldst", cyc);
        read_reg(7, v); check_val("ldst_r7", 32'(v), 32'h1AB);
        check_val("ldst_cycles20", 32'(cyc), 32'd20);
        check_val("ldst_dmem3", 32'(m_dmem[3]), 32'h1AB);

        clear_prog();
        prog[0] = enc_i9(2, 1, 1); prog[1] = enc_i9(6, 0, 3);
        prog[3] = enc_i9(5, 1, 5); prog[4] = enc_i9(5, 0, 9'h1FE);
        load_prog();
        run_prog("branch", cyc);
        check_val("branch_pc2", 32'(Pc_o), 32'd2);
        check_val("branch_ret5", 32'(Retired_o), 32'd5);
        check_val("branch_cycles16", 32'(cyc), 32'd16);

        // Reset landing on the WB of the ALU instruction (busy cycle 12).
        clear_prog();
        prog[0] = enc_i9(2, 1, 5); prog[1] = enc_i9(2, 2, 7); prog[2] = enc_r(3, 3, 1, 2, 0);
        load_prog();
        pulse_start();
        repeat (11) @(negedge Clk_i);
        Rst_i = 1'b1;
        @(negedge Clk_i);
        Rst_i = 1'b0;
        model_reset();
        @(negedge Clk_i);
        read_reg(3, v); check_val("abort_r3", 32'(v), 32'd0);
        read_reg(1, v); check_val("abort_r1", 32'(v), 32'd0);
        check_val("abort_busy", 32'(Busy_o), 32'd0);
        check_val("abort_halt", 32'(Halt_o), 32'd0);
        check_val("abort_pc", 32'(Pc_o), 32'd0);
        $display("run abort: pc=%0d busy=%0d", Pc_o, Busy_o);

        clear_prog();
        prog[0] = enc_i9(5, 9, 2); prog[2] = enc_i9(2, 9, 1); prog[3] = enc_i9(6, 0, 63);
        prog[63] = enc_i9(2, 10, 9'h55);
        load_prog();
        run_prog("jmpwrap", cyc);
        read_reg(10, v); check_val("jmpwrap_r10", 32'(v), 32'h55);
        check_val("jmpwrap_pc1", 32'(Pc_o), 32'd1);
        check_val("jmpwrap_ret6", 32'(Retired_o), 32'd6);

        // Instruction RAM writes while busy must be ignored.
        clear_prog();
        prog[0] = enc_i9(2, 1, 5); prog[1] = enc_i9(2, 2, 7); prog[2] = enc_r(3, 3, 1, 2, 0);
        load_prog();
        pulse_start();
        Inst_wen_i = 1'b1; Inst_waddr_i = 6'd3; Input_inst_i = enc_i9(2, 5, 9'h77);
        @(negedge Clk_i);
        @(negedge Clk_i);
        Inst_wen_i = 1'b0;
        wait_halt(2, cyc);
        model_run(mcyc);
        compare_run("busywr", cyc, mcyc);
        run_prog("reread", cyc);
        check_val("reread_pc3", 32'(Pc_o), 32'd3);

        // From HALTED: rewrite address 1, then write address 0 in the same cycle as Start.
        @(negedge Clk_i);
        Inst_wen_i = 1'b1; Inst_waddr_i = 6'd1; Input_inst_i = HALT; m_imem[1] = HALT;
        @(negedge Clk_i);
        Inst_waddr_i = 6'd0; Input_inst_i = enc_i9(2, 0, 9); m_imem[0] = enc_i9(2, 0, 9);
        Start_i = 1'b1;
        @(negedge Clk_i);
        Inst_wen_i = 1'b0; Start_i = 1'b0;
        check_val("restart_ret0", 32'(Retired_o), 32'd0);
        check_val("restart_busy", 32'(Busy_o), 32'd1);
        wait_halt(0, cyc);
        model_run(mcyc);
        compare_run("restart", cyc, mcyc);
        read_reg(0, v); check_val("restart_r0", 32'(v), 32'd0);
        check_val("restart_ret2", 32'(Retired_o), 32'd2);

        for (int k = 0; k < 8; k++) begin
            clear_prog();
            len = int'($urandom_range(6, 20));
            for (int i = 0; i < len; i++) begin
                kind = int'($urandom_range(0, 5));
                case (kind)
                    0: prog[i] = enc_i5(0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 31)));
                    1: prog[i] = enc_i5(1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 31)));
                    2: prog[i] = enc_i9(2, int'($urandom_range(0, 15)), int'($urandom_range(0, 511)));
                    3: prog[i] = enc_r(3, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
                    4: prog[i] = enc_r(4, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
                    default: prog[i] = enc_i9(5, int'($urandom_range(0, 15)), int'($urandom_range(1, 3)));
                endcase
            end
            load_prog();
            run_prog($sformatf("rand%0d", k), cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
